// File: rtl/wm_plant_model_if.sv
// Actuator commands from the washing-machine controller and the sensor/timeout
// feedback returned by the plant model.
interface wm_plant_model_if #(
   parameter int LEVEL_W = 4
);
   logic               fill_valve_on;
   logic               drain_valve_on;
   logic               motor_on;
   logic               soap_wash;
   logic               water_wash;
   logic               door_lock;
   logic               done;
   logic               filled;
   logic               drained;
   logic               detergent_added;
   logic               cycle_timeout;
   logic               spin_timeout;
   logic [LEVEL_W-1:0] water_level;
   logic               fault;

   modport master (
      output fill_valve_on, drain_valve_on, motor_on, soap_wash, water_wash,
             door_lock, done,
      input  filled, drained, detergent_added, cycle_timeout, spin_timeout,
             water_level, fault
   );

   modport slave (
      input  fill_valve_on, drain_valve_on, motor_on, soap_wash, water_wash,
             door_lock, done,
      output filled, drained, detergent_added, cycle_timeout, spin_timeout,
             water_level, fault
   );
endinterface

// File: rtl/wm_plant_model.sv
// Synthesizable washing-machine plant: tank level, detergent dispenser, wash
// and spin timers, plus a sticky flag for illegal actuator combinations.
module wm_plant_model #(
   parameter int LEVEL_W     = 4,
   parameter int LEVEL_MAX   = 8,
   parameter int DOSE_CYCLES = 4,
   parameter int WASH_CYCLES = 20,
   parameter int SPIN_CYCLES = 12
) (
   input  logic           clk,
   input  logic           reset,
   wm_plant_model_if.slave bus
);
   localparam int DW = $clog2(DOSE_CYCLES + 1);
   localparam int WW = $clog2(WASH_CYCLES + 1);
   localparam int SW = $clog2(SPIN_CYCLES + 1);

   localparam logic [LEVEL_W-1:0] LVL_FULL  = LEVEL_W'(LEVEL_MAX);
   localparam logic [DW-1:0]      DOSE_LAST = DW'(DOSE_CYCLES - 1);
   localparam logic [WW-1:0]      WASH_SAT  = WW'(WASH_CYCLES);
   localparam logic [SW-1:0]      SPIN_SAT  = SW'(SPIN_CYCLES);

   typedef enum logic [1:0] {
      D_IDLE,
      D_DOSING,
      D_DONE
   } dose_state_e;

   dose_state_e        state_q;
   logic [DW-1:0]      dose_cnt_q;
   logic               det_q;

   logic [LEVEL_W-1:0] level_q, level_d;
   logic [WW-1:0]      wash_q, wash_d;
   logic [SW-1:0]      spin_q, spin_d;
   logic               fault_q, fault_d;

   logic filled, drained, dose_start, spin_cond, illegal;

   assign filled  = (level_q == LVL_FULL);
   assign drained = (level_q == '0);

   assign dose_start = bus.soap_wash && filled && !bus.fill_valve_on && !bus.water_wash;
   assign spin_cond  = bus.drain_valve_on && drained && bus.water_wash && !bus.motor_on;
   assign illegal    = (bus.fill_valve_on && bus.drain_valve_on)
                     || (bus.motor_on && drained)
                     || (!bus.door_lock
                         && (bus.fill_valve_on || bus.drain_valve_on || bus.motor_on));

   always_comb begin
      level_d = level_q;
      if (bus.fill_valve_on && !bus.drain_valve_on && !filled)
         level_d = level_q + LEVEL_W'(1);
      else if (bus.drain_valve_on && !bus.fill_valve_on && !drained)
         level_d = level_q - LEVEL_W'(1);
   end

   always_comb begin
      wash_d = '0;
      if (bus.motor_on && filled)
         wash_d = (wash_q == WASH_SAT) ? wash_q : wash_q + WW'(1);
   end

   always_comb begin
      spin_d = '0;
      if (spin_cond && !bus.done)
         spin_d = (spin_q == SPIN_SAT) ? spin_q : spin_q + SW'(1);
   end

   assign fault_d = fault_q || illegal;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_q <= '0;
         wash_q  <= '0;
         spin_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         level_q <= level_d;
         wash_q  <= wash_d;
         spin_q  <= spin_d;
         fault_q <= fault_d;
      end
   end

   // The entry edge counts as the first dose edge, so the counter starts at 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= D_IDLE;
         dose_cnt_q <= '0;
         det_q      <= 1'b0;
      end else if (bus.done || !bus.door_lock) begin
         state_q    <= D_IDLE;
         dose_cnt_q <= '0;
         det_q      <= 1'b0;
      end else begin
         unique case (state_q)
            D_IDLE: begin
               if (dose_start) begin
                  state_q    <= D_DOSING;
                  dose_cnt_q <= DW'(1);
               end
            end
            D_DOSING: begin
               if (!bus.soap_wash) begin
                  state_q    <= D_IDLE;
                  dose_cnt_q <= '0;
               end else if (dose_cnt_q == DOSE_LAST) begin
                  state_q    <= D_DONE;
                  dose_cnt_q <= '0;
                  det_q      <= 1'b1;
               end else begin
                  dose_cnt_q <= dose_cnt_q + DW'(1);
               end
            end
            D_DONE: begin
               det_q <= 1'b1;
            end
            default: begin
               state_q    <= D_IDLE;
               dose_cnt_q <= '0;
               det_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.filled          = filled;
   assign bus.drained         = drained;
   assign bus.detergent_added = det_q;
   assign bus.cycle_timeout   = (wash_q == WASH_SAT);
   assign bus.spin_timeout    = (spin_q == SPIN_SAT);
   assign bus.water_level     = level_q;
   assign bus.fault           = fault_q;
endmodule

// File: tb/tb_wm_plant_model.sv
// Closed-loop bench for wm_plant_model: directed scenarios followed by random
// held-input phases, every output compared with an arithmetic plant model.
module tb_wm_plant_model;
   localparam int LEVEL_W     = 4;
   localparam int LEVEL_MAX   = 8;
   localparam int DOSE_CYCLES = 4;
   localparam int WASH_CYCLES = 20;
   localparam int SPIN_CYCLES = 12;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   wm_plant_model_if #(.LEVEL_W(LEVEL_W)) bus ();

   wm_plant_model #(
      .LEVEL_W    (LEVEL_W),
      .LEVEL_MAX  (LEVEL_MAX),
      .DOSE_CYCLES(DOSE_CYCLES),
      .WASH_CYCLES(WASH_CYCLES),
      .SPIN_CYCLES(SPIN_CYCLES)
   ) dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Plant model state: plain integers, updated once per rising edge.
   int m_level, m_dose, m_wash, m_spin;
   bit m_det, m_fault;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_level = 0; m_dose = 0; m_wash = 0; m_spin = 0;
      m_det = 1'b0; m_fault = 1'b0;
   endtask

   task automatic model_edge();
      bit full, empty, f, d, m, sw, ww, lk, dn;
      full  = (m_level == LEVEL_MAX);
      empty = (m_level == 0);
      f = bus.fill_valve_on; d = bus.drain_valve_on; m = bus.motor_on;
      sw = bus.soap_wash; ww = bus.water_wash; lk = bus.door_lock; dn = bus.done;

      if (f && !d)      m_level = (m_level < LEVEL_MAX) ? m_level + 1 : LEVEL_MAX;
      else if (d && !f) m_level = (m_level > 0) ? m_level - 1 : 0;

      if (dn || !lk) begin
         m_dose = 0; m_det = 1'b0;
      end else if (!m_det) begin
         if (m_dose == 0) begin
            if (sw && full && !f && !ww) m_dose = 1;
         end else if (!sw) m_dose = 0;
         else m_dose++;
         if (m_dose == DOSE_CYCLES) m_det = 1'b1;
      end

      m_wash = (m && full) ? ((m_wash < WASH_CYCLES) ? m_wash + 1 : WASH_CYCLES) : 0;
      m_spin = (d && empty && ww && !m && !dn)
             ? ((m_spin < SPIN_CYCLES) ? m_spin + 1 : SPIN_CYCLES) : 0;

      if ((f && d) || (m && empty) || (!lk && (f || d || m))) m_fault = 1'b1;
   endtask

   task automatic check_all();
      check("water_level",     32'(bus.water_level),     m_level);
      check("filled",          32'(bus.filled),          32'(m_level == LEVEL_MAX));
      check("drained",         32'(bus.drained),         32'(m_level == 0));
      check("detergent_added", 32'(bus.detergent_added), 32'(m_det));
      check("cycle_timeout",   32'(bus.cycle_timeout),   32'(m_wash == WASH_CYCLES));
      check("spin_timeout",    32'(bus.spin_timeout),    32'(m_spin == SPIN_CYCLES));
      check("fault",           32'(bus.fault),           32'(m_fault));
   endtask

   task automatic apply(input bit f, input bit d, input bit m, input bit sw,
                        input bit ww, input bit lk, input bit dn);
      bus.fill_valve_on  = f;
      bus.drain_valve_on = d;
      bus.motor_on       = m;
      bus.soap_wash      = sw;
      bus.water_wash     = ww;
      bus.door_lock      = lk;
      bus.done           = dn;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         #1;
         check_all();
      end
   endtask

   // Called away from the clock edge; checks the asynchronous effect first.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
   endtask

   initial begin
      apply(0, 0, 0, 0, 0, 0, 0);
      #2;
      do_reset();

      tick(10);
      check("idle_drained", 32'(bus.drained), 1);

      apply(1, 0, 0, 0, 0, 1, 0);
      tick(1);
      check("fill_e1_drained", 32'(bus.drained), 0);
      tick(7);
      check("fill_e8_level", 32'(bus.water_level), 8);
      check("fill_e8_filled", 32'(bus.filled), 1);
      tick(2);
      check("fill_sat_level", 32'(bus.water_level), 8);

      apply(0, 0, 0, 1, 0, 1, 0);
      tick(3);
      check("dose_e3", 32'(bus.detergent_added), 0);
      tick(1);
      check("dose_e4", 32'(bus.detergent_added), 1);
      apply(0, 0, 0, 1, 0, 1, 1);
      tick(1);
      check("dose_done_clr", 32'(bus.detergent_added), 0);
      apply(0, 0, 0, 0, 0, 1, 0);
      tick(1);

      apply(0, 0, 1, 0, 0, 1, 0);
      tick(19);
      check("wash_e19", 32'(bus.cycle_timeout), 0);
      tick(1);
      check("wash_e20", 32'(bus.cycle_timeout), 1);
      apply(0, 0, 0, 0, 0, 1, 0);
      tick(1);
      check("wash_drop", 32'(bus.cycle_timeout), 0);
      apply(0, 0, 1, 0, 0, 1, 0);
      tick(10);
      apply(0, 0, 0, 0, 0, 1, 0);
      tick(1);
      apply(0, 0, 1, 0, 0, 1, 0);
      tick(19);
      check("wash_restart_e19", 32'(bus.cycle_timeout), 0);
      tick(1);
      check("wash_restart_e20", 32'(bus.cycle_timeout), 1);
      apply(0, 0, 0, 0, 0, 1, 0);
      tick(1);

      apply(0, 1, 0, 0, 1, 1, 0);
      tick(7);
      check("drain_e7", 32'(bus.drained), 0);
      tick(1);
      check("drain_e8", 32'(bus.drained), 1);
      tick(11);
      check("spin_e11", 32'(bus.spin_timeout), 0);
      tick(1);
      check("spin_e12", 32'(bus.spin_timeout), 1);
      apply(0, 0, 0, 0, 0, 1, 0);
      tick(1);
      check("spin_drop", 32'(bus.spin_timeout), 0);

      apply(1, 0, 0, 0, 0, 1, 0);
      tick(3);
      apply(1, 1, 0, 0, 0, 1, 0);
      tick(1);
      check("both_valves_fault", 32'(bus.fault), 1);
      check("both_valves_level", 32'(bus.water_level), 3);
      apply(0, 0, 0, 0, 0, 1, 0);
      tick(5);
      check("fault_sticky", 32'(bus.fault), 1);
      do_reset();
      check("fault_cleared", 32'(bus.fault), 0);
      apply(0, 0, 1, 0, 0, 1, 0);
      tick(1);
      check("dry_run_fault", 32'(bus.fault), 1);
      apply(0, 0, 0, 0, 0, 1, 0);
      tick(1);

      do_reset();
      apply(1, 0, 0, 0, 0, 1, 0);
      tick(9);
      apply(0, 0, 1, 0, 0, 1, 0);
      tick(5);
      do_reset();
      check("midwash_reset_level", 32'(bus.water_level), 0);

      for (int p = 0; p < 80; p++) begin
         apply($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0,
               $urandom_range(0, 9) == 0);
         tick(int'($urandom_range(1, 24)));
         if ($urandom_range(0, 24) == 0) do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/wm_plant_model.md
Name: wm_plant_model

Overview:
- Behavioural-but-synthesizable model of the washing-machine drum, valves, dispenser and timers.
- Sits on the sensor side of the washing-machine controller: consumes its actuator outputs and produces its sensor/timeout inputs.
- Used for closed-loop simulation and for FPGA demo boards where no real plant exists.
- Also flags illegal actuator combinations to the bench.

Parameters:
- LEVEL_W, 4, width of water level counter.
- LEVEL_MAX, 8, level at which tank is full (must be < 2**LEVEL_W).
- DOSE_CYCLES, 4, clock cycles to dispense detergent.
- WASH_CYCLES, 20, motor-on cycles with full tank before cycle_timeout.
- SPIN_CYCLES, 12, spin-condition cycles before spin_timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- fill_valve_on  in  1  controller fill valve command.
- drain_valve_on  in  1  controller drain valve command.
- motor_on  in  1  controller motor command.
- soap_wash  in  1  controller soap-phase flag.
- water_wash  in  1  controller rinse-phase flag.
- door_lock  in  1  controller door lock command.
- done  in  1  controller end-of-program flag.
- filled  out  1  level == LEVEL_MAX.
- drained  out  1  level == 0.
- detergent_added  out  1  dose complete (sticky).
- cycle_timeout  out  1  wash timer expired.
- spin_timeout  out  1  spin timer expired.
- water_level  out  LEVEL_W  current level.
- fault  out  1  sticky illegal-command flag.

Behaviour:
- All outputs are decoded from registers only; there is no combinational input-to-output path.
- Reset (reset=0, any time, asynchronous) values:
  - level=0, so drained=1 and filled=0.
  - All counters 0.
  - detergent_added=0, cycle_timeout=0, spin_timeout=0, fault=0.
- Level, updated per rising edge:
  - fill_valve_on & !drain_valve_on: +1, saturating at LEVEL_MAX.
  - drain_valve_on & !fill_valve_on: -1, saturating at 0.
  - Both or neither: hold.
  - filled and drained follow the level register in the same cycle.
- Dispenser: states D_IDLE, D_DOSING, D_DONE.
  - D_IDLE -> D_DOSING when soap_wash & filled & !fill_valve_on & !water_wash.
  - D_DOSING counts DOSE_CYCLES edges, then goes to D_DONE.
  - D_DONE drives detergent_added=1 and holds it.
  - Any state -> D_IDLE when done=1 or door_lock=0; this takes priority over dosing.
  - Dropping soap_wash mid-dose aborts to D_IDLE with the counter cleared.
- Wash timer:
  - Counts while motor_on & filled; saturates at WASH_CYCLES.
  - cycle_timeout=1 while count == WASH_CYCLES.
  - Count clears to 0 on any cycle with motor_on=0 or filled=0, so cycle_timeout falls one edge after motor_on falls.
  - Reaching WASH_CYCLES requires that many consecutive qualifying cycles.
- Spin timer:
  - Counts while drain_valve_on & drained & water_wash & !motor_on; saturates at SPIN_CYCLES.
  - spin_timeout=1 at saturation.
  - Clears when the condition drops or done=1.
  - The one-cycle overlap at the drain-to-spin handover counts toward SPIN_CYCLES; this is accepted.
- Fault: set and held until reset on any edge where one of these is true:
  - fill_valve_on & drain_valve_on.
  - motor_on & drained (dry run).
  - Any actuator on while door_lock=0.
  - fault does not alter the other behaviour.
- Simultaneous events:
  - Fill command on an edge where the level is already LEVEL_MAX: level holds at LEVEL_MAX, no wrap.
  - done and a dose-start condition on the same edge: done wins.

Test Plan:
- Reset release, all inputs 0:
  - water_level=0, drained=1.
  - All other outputs 0 for 10 cycles.
- fill_valve_on=1 for 10 cycles:
  - drained=0 after the 1st edge.
  - water_level=8 and filled=1 after the 8th edge; still 8 after the 10th edge.
- Tank full, soap_wash=1, door_lock=1, fill_valve_on=0:
  - detergent_added=1 after 4 edges.
  - Pulse done=1 -> detergent_added=0 next edge.
- Tank full, motor_on=1:
  - cycle_timeout=1 after the 20th edge.
  - Drop motor_on -> cycle_timeout=0 one edge later.
  - Repeat with motor_on dropped at edge 10 -> no timeout, and the count restarts from 0.
- Rinse drain from level 8 with water_wash=1, drain_valve_on=1:
  - drained=1 after 8 edges.
  - spin_timeout=1 12 edges later.
- Illegal commands:
  - fill_valve_on & drain_valve_on for 1 cycle -> fault=1, level unchanged, fault held until reset=0.
  - From reset, motor_on=1 with empty tank -> fault=1.
  - Assert reset mid-wash -> all outputs return to reset values immediately.
